// File: rtl/mat_mul_loader_pkg.sv
// Shared definitions for the matrix-multiply operand loader: state encoding
// and the beat-count derivation used to size the frame register.
package mat_mul_loader_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int beats_of(input int n, input int w_in, input int bus_w);
        return (2 * n * n) / (bus_w / w_in);
    endfunction

    // Keep the counter at least one bit wide even for a single-beat frame.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/mat_mul_loader_if.sv
// Narrow valid/ready beat stream feeding the loader; the upstream drives
// the master side and the loader is the slave.
interface mat_mul_loader_if #(
    parameter int BUS_W = 64
);
    logic [BUS_W-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/mat_mul_loader.sv
// Assembles one operand frame (matrix_1 then matrix_2) from the beat stream
// and pulses valid_out once complete; malformed frames are dropped with frame_err.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_FILL  | accepting beats into the frame register, counting to BEATS-1
//  ST_FIRE  | one-cycle valid_out pulse, upstream stalled
//  ST_DRAIN | discarding beats after a missing s_last until one carries it
module mat_mul_loader
    import mat_mul_loader_pkg::*;
#(
    parameter int W_IN  = 8,
    parameter int N     = 8,
    parameter int BUS_W = 64
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    mat_mul_loader_if.slave        beat,
    output logic                   valid_out,
    output logic [2*N*N*W_IN-1:0]  data_out,
    output logic                   frame_err
);

    localparam int E     = BUS_W / W_IN;
    localparam int BEATS = beats_of(N, W_IN, BUS_W);
    localparam int CW    = cnt_width(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if ((E == 0) || ((BUS_W % W_IN) != 0) || (((2 * N * N) % ((E == 0) ? 1 : E)) != 0))
    begin : g_param_check
        $error("mat_mul_loader: BUS_W must hold a whole number of elements dividing 2*N*N");
    end

    state_t           state;
    logic [CW-1:0]    beat_cnt;
    logic             ready_q;
    logic [BUS_W-1:0] frame [BEATS];
    logic             hs;

    assign beat.s_ready = ready_q;
    assign hs           = beat.s_valid & ready_q;

    always_comb begin
        data_out = '0;
        for (int b = 0; b < BEATS; b++) begin
            data_out[b*BUS_W +: BUS_W] = frame[b];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_FILL;
            beat_cnt  <= '0;
            ready_q   <= 1'b0;
            valid_out <= 1'b0;
            frame_err <= 1'b0;
            for (int b = 0; b < BEATS; b++) begin
                frame[b] <= '0;
            end
        end else begin
            valid_out <= 1'b0;
            frame_err <= 1'b0;
            ready_q   <= 1'b1;
            // Flush outranks a same-cycle beat; a FIRE pulse is already on the wire.
            if (flush) begin
                state    <= ST_FILL;
                beat_cnt <= '0;
            end else begin
                case (state)
                    ST_FILL: begin
                        if (hs) begin
                            frame[beat_cnt] <= beat.s_data;
                            if (beat_cnt == LAST_BEAT) begin
                                beat_cnt <= '0;
                                if (beat.s_last) begin
                                    state     <= ST_FIRE;
                                    valid_out <= 1'b1;
                                    ready_q   <= 1'b0;
                                end else begin
                                    state     <= ST_DRAIN;
                                    frame_err <= 1'b1;
                                end
                            end else if (beat.s_last) begin
                                beat_cnt  <= '0;
                                frame_err <= 1'b1;
                            end else begin
                                beat_cnt <= beat_cnt + CW'(1);
                            end
                        end
                    end
                    ST_FIRE: begin
                        state <= ST_FILL;
                    end
                    ST_DRAIN: begin
                        if (hs && beat.s_last) begin
                            state <= ST_FILL;
                        end
                    end
                    default: begin
                        state    <= ST_FILL;
                        beat_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
